// File: rtl/cr_coeff_serializer_pkg.sv
// Shared types and zigzag table for the Cr coefficient serializer.
// The zigzag table is only referenced when CR_SER_ZIGZAG_EN is defined.
package cr_ser_pkg;

   localparam int COEFF_W = 11;
   localparam int N_COEFF = 64;

   typedef logic signed [COEFF_W-1:0] coeff_t;
   typedef coeff_t [N_COEFF-1:0] coeff_blk_t;
   typedef logic [5:0] idx_t;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   // JPEG zigzag: beat number -> raster index
   localparam idx_t ZIGZAG [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/cr_zigzag_lut.sv
// Combinational beat-number to raster-index lookup (zigzag order).
// Instantiated only when CR_SER_ZIGZAG_EN is defined.
import cr_ser_pkg::*;

module cr_zigzag_lut (
   input  idx_t beat,
   output idx_t raster
);

   assign raster = ZIGZAG[beat];

endmodule

// File: rtl/cr_coeff_serializer.sv
// Cr DCT block capture into a two-bank ping-pong buffer, streamed out one
// coefficient per valid/ready beat. Define CR_SER_ZIGZAG_EN for zigzag order.
import cr_ser_pkg::*;

module cr_coeff_serializer (
   input  logic       clk,
   input  logic       rst,
   input  coeff_blk_t coeff_in,
   input  logic       coeff_valid,
   output coeff_t     out_data,
   output idx_t       out_index,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       overflow,
   output logic       busy
);

   coeff_blk_t bank [2];
   state_t     state;
   logic       cv_q;
   logic       wr_bank;
   logic       rd_bank;
   logic [1:0] count;
   logic [1:0] count_nxt;
   idx_t       beat;
   idx_t       order_idx;
   logic       cap;
   logic       fire;
   logic       fin;
   logic       accept;
   logic       drop;

`ifdef CR_SER_ZIGZAG_EN
   cr_zigzag_lut u_lut (
      .beat   (beat),
      .raster (order_idx)
   );
`else
   assign order_idx = beat;
`endif

   assign cap  = coeff_valid & ~cv_q;
   assign fire = out_valid & out_ready;
   assign fin  = fire & (beat == 6'd63);

   // A full buffer still accepts if a bank frees up on this same edge
   assign accept = cap & ((count != 2'd2) | fin);
   assign drop   = cap & ~accept;

   assign count_nxt = count + {1'b0, accept} - {1'b0, fin};

   assign busy      = (count != 2'd0);
   assign out_last  = out_valid & (beat == 6'd63);
   assign out_index = out_valid ? order_idx : '0;
   assign out_data  = out_valid ? bank[rd_bank][order_idx] : '0;

   always_ff @(posedge clk) begin
      if (rst && accept)
         bank[wr_bank] <= coeff_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         cv_q      <= 1'b0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         count     <= 2'd0;
         beat      <= '0;
         overflow  <= 1'b0;
      end else begin
         cv_q  <= coeff_valid;
         count <= count_nxt;
         if (accept)
            wr_bank <= ~wr_bank;
         if (drop)
            overflow <= 1'b1;
         if (fire)
            beat <= beat + 6'd1;
         if (fin)
            rd_bank <= ~rd_bank;
         unique case (state)
            IDLE: begin
               if (count_nxt != 2'd0) begin
                  state     <= STREAM;
                  out_valid <= 1'b1;
               end
            end
            STREAM: begin
               if (fin && count_nxt == 2'd0) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cr_coeff_serializer.sv
// Scoreboard bench for cr_coeff_serializer: directed blocks in, queued
// expected beats popped and compared by an independent monitor.
import cr_ser_pkg::*;

module tb_cr_coeff_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   coeff_blk_t coeff_in = '0;
   logic       coeff_valid = 1'b0;
   coeff_t     out_data;
   idx_t       out_index;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       overflow;
   logic       busy;

   typedef struct packed {
      coeff_t d;
      idx_t   i;
      logic   l;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   mode = 0;
   logic tog = 1'b0;
   int   cyc = 0;
   int   vcount = 0;
   int   first_c = 0;
   int   last_c = 0;
   logic lat_valid = 1'b0;

`ifdef CR_SER_ZIGZAG_EN
   int ZZ [64] = '{
      0,  1,  8,  16, 9,  2,  3,  10,
      17, 24, 32, 25, 18, 11, 4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13, 6,  7,  14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };
`endif

   cr_coeff_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .coeff_in    (coeff_in),
      .coeff_valid (coeff_valid),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ord(input int b);
`ifdef CR_SER_ZIGZAG_EN
      return ZZ[b];
`else
      return b;
`endif
   endfunction

   // kind 0: k-32, 1: k, 2: -k, 3: constant v
   function automatic coeff_blk_t mk(input int kind, input int v);
      coeff_blk_t blk;
      for (int k = 0; k < 64; k++) begin
         case (kind)
            0:       blk[k] = coeff_t'(k - 32);
            1:       blk[k] = coeff_t'(k);
            2:       blk[k] = coeff_t'(-k);
            default: blk[k] = coeff_t'(v);
         endcase
      end
      return blk;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic push_blk(input coeff_blk_t blk);
      exp_t e;
      for (int b = 0; b < 64; b++) begin
         e.i = idx_t'(ord(b));
         e.d = blk[ord(b)];
         e.l = (b == 63);
         q.push_back(e);
      end
   endtask

   task automatic drive_blk(input coeff_blk_t blk);
      @(posedge clk);
      #1;
      coeff_in    = blk;
      coeff_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat_valid = out_valid;
      @(posedge clk);
      #1;
      coeff_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int max);
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < max) begin
         @(posedge clk);
         #6;
         n++;
      end
      if (n >= max) begin
         n_chk++;
         $display("FAIL %s_timeout: got %0d beats left, expected 0", nm, q.size());
      end
   endtask

   // Ready driver: 0 = always ready, 1 = alternate starting stalled, 2 = never
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mode == 0)
            out_ready = 1'b1;
         else if (mode == 2)
            out_ready = 1'b0;
         else begin
            out_ready = out_valid ? tog : 1'b0;
            if (out_valid)
               tog = ~tog;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (vcount == 0)
            first_c = cyc;
         last_c = cyc;
         vcount++;
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_beat: got idx %0d data %0d, expected no beat",
                     out_index, out_data);
         end else if ({out_data, out_index, out_last} === {q[0].d, q[0].i, q[0].l}) begin
            n_pass++;
            if (out_ready)
               void'(q.pop_front());
         end else begin
            $display("FAIL beat: got d=%0d i=%0d l=%0d, expected d=%0d i=%0d l=%0d",
                     out_data, out_index, out_last, q[0].d, q[0].i, q[0].l);
            if (out_ready)
               void'(q.pop_front());
         end
      end
   end

   initial begin
      // reset state
      #12;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_last", int'(out_last), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_index", int'(out_index), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("idle_valid", int'(out_valid), 0);

      // single block, always ready
      mode = 0;
      vcount = 0;
      push_blk(mk(0, 0));
      drive_blk(mk(0, 0));
      chk("latency", int'(lat_valid), 1);
      wait_drain("single", 200);
      chk("single_beats", vcount, 64);

      // alternating ready
      mode = 1;
      tog = 1'b0;
      vcount = 0;
      push_blk(mk(0, 0));
      drive_blk(mk(0, 0));
      wait_drain("stall", 400);
      chk("stall_cycles", vcount, 128);
      chk("stall_span", last_c - first_c + 1, 128);

      // back-to-back blocks
      mode = 0;
      vcount = 0;
      push_blk(mk(1, 0));
      push_blk(mk(2, 0));
      drive_blk(mk(1, 0));
      repeat (8) @(posedge clk);
      drive_blk(mk(2, 0));
      wait_drain("b2b", 400);
      chk("b2b_cycles", vcount, 128);
      chk("b2b_span", last_c - first_c + 1, 128);

      // overflow: third block dropped
      mode = 2;
      @(posedge clk);
      push_blk(mk(3, 100));
      push_blk(mk(3, 200));
      drive_blk(mk(3, 100));
      drive_blk(mk(3, 200));
      drive_blk(mk(3, 300));
      @(negedge clk);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_busy", int'(busy), 1);
      mode = 0;
      wait_drain("ovf", 400);
      chk("ovf_sticky", int'(overflow), 1);
      chk("ovf_idle_busy", int'(busy), 0);

      // reset mid-stream
      push_blk(mk(1, 0));
      drive_blk(mk(1, 0));
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_overflow", int'(overflow), 0);
      chk("midrst_last", int'(out_last), 0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("postrst_valid", int'(out_valid), 0);
      chk("postrst_busy", int'(busy), 0);

      // held coeff_valid gives one capture
      vcount = 0;
      push_blk(mk(3, -7));
      @(posedge clk);
      #1;
      coeff_in    = mk(3, -7);
      coeff_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      coeff_valid = 1'b0;
      wait_drain("hold", 200);
      repeat (5) @(posedge clk);
      chk("hold_beats", vcount, 64);

      // capture coincident with final beat while both banks full
      vcount = 0;
      push_blk(mk(1, 0));
      push_blk(mk(2, 0));
      push_blk(mk(3, 5));
      drive_blk(mk(1, 0));
      repeat (10) @(posedge clk);
      drive_blk(mk(2, 0));
      repeat (48) @(posedge clk);
      @(posedge clk);
      #1;
      coeff_in    = mk(3, 5);
      coeff_valid = 1'b1;
      @(negedge clk);
      chk("coinc_last", int'(out_last), 1);
      chk("coinc_busy", int'(busy), 1);
      @(posedge clk);
      #1;
      coeff_valid = 1'b0;
      @(negedge clk);
      chk("coinc_overflow", int'(overflow), 0);
      wait_drain("coinc", 800);
      chk("coinc_beats", vcount, 192);
      chk("coinc_span", last_c - first_c + 1, 192);
      chk("coinc_overflow_end", int'(overflow), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
